// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freeze, saturating stall counter and sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_use_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_mem_req_i,
    input  logic             dmem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             memwb_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // state    | meaning
    // BOOT     | first cycle after reset, every stage loads a bubble
    // RUN      | normal issue; load-use and branch handling active
    // MEM_WAIT | data memory withholding ready, pipeline frozen
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              active;
    logic              freeze;
    logic              loaduse;

    assign active  = (state != BOOT);
    assign freeze  = exmem_mem_req_i & ~dmem_ready_i;
    assign loaduse = idex_memread_i & (idex_rt_i != 5'd0) &
                     ((idex_rt_i == ifid_rs_i) |
                      (ifid_use_rt_i & (idex_rt_i == ifid_rt_i)));

    // Controls are decoded in the same cycle as the hazard so the stage registers
    // react before the next edge; BOOT values double as the fallback.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_write_o  = 1'b0;
        idex_flush_o  = 1'b1;
        exmem_write_o = 1'b0;
        memwb_flush_o = 1'b1;
        if (active) begin
            if (freeze) begin
                ifid_flush_o  = 1'b0;
                idex_flush_o  = 1'b0;
                memwb_flush_o = 1'b1;
            end else if (loaduse) begin
                ifid_flush_o  = 1'b0;
                idex_write_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_write_o = 1'b1;
                memwb_flush_o = 1'b0;
            end else begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                ifid_flush_o  = branch_taken_i;
                idex_write_o  = 1'b1;
                idex_flush_o  = 1'b0;
                exmem_write_o = 1'b1;
                memwb_flush_o = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:     state <= RUN;
                RUN:      if (freeze) state <= MEM_WAIT;
                MEM_WAIT: if (!freeze) state <= RUN;
                default:  state <= BOOT;
            endcase
        end
    end

    // Wait counter tracks consecutive freeze cycles only; any break restarts it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (active && freeze) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == WAIT_LAST) err_o <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (active && !pc_write_o && stall_cnt_o != STALL_MAX) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued as
// stimulus is applied and compared against sampled outputs per scenario.
module tb_pipe_hazard_ctrl;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush}
    localparam logic [6:0] C_BOOT   = 7'b0010101;
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_BRANCH = 7'b1111010;
    localparam logic [6:0] C_LU     = 7'b0001110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       memread = 1'b0;
    logic [4:0] idex_rt = '0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       use_rt = 1'b0;
    logic       br = 1'b0;
    logic       req = 1'b0;
    logic       rdy = 1'b1;
    logic       clr = 1'b0;

    logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, err;
    logic [15:0] stall_cnt;
    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_w, s_idex_f, s_exmem_w, s_memwb_f, s_err;
    logic [3:0]  s_stall_cnt;
    logic [6:0]  ctrl;

    assign ctrl = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f};

    int tests_run = 0;
    int failed = 0;
    int exp_stall16 = 0;
    int exp_stall4 = 0;
    logic [6:0] exp_q[$];
    logic [6:0] act_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .idex_memread_i(memread), .idex_rt_i(idex_rt), .ifid_rs_i(ifid_rs),
        .ifid_rt_i(ifid_rt), .ifid_use_rt_i(use_rt), .branch_taken_i(br),
        .exmem_mem_req_i(req), .dmem_ready_i(rdy), .cnt_clr_i(clr),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
        .idex_write_o(idex_w), .idex_flush_o(idex_f), .exmem_write_o(exmem_w),
        .memwb_flush_o(memwb_f), .err_o(err), .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_n),
        .idex_memread_i(memread), .idex_rt_i(idex_rt), .ifid_rs_i(ifid_rs),
        .ifid_rt_i(ifid_rt), .ifid_use_rt_i(use_rt), .branch_taken_i(br),
        .exmem_mem_req_i(req), .dmem_ready_i(rdy), .cnt_clr_i(clr),
        .pc_write_o(s_pc_w), .ifid_write_o(s_ifid_w), .ifid_flush_o(s_ifid_f),
        .idex_write_o(s_idex_w), .idex_flush_o(s_idex_f), .exmem_write_o(s_exmem_w),
        .memwb_flush_o(s_memwb_f), .err_o(s_err), .stall_cnt_o(s_stall_cnt)
    );

    // Called at posedge+1: drive one cycle, queue expectation, sample, advance.
    task automatic apply(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] irt, input logic ur, input logic b,
                         input logic rq, input logic rd, input logic cl,
                         input logic [6:0] exp_ctrl);
        memread = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = irt; use_rt = ur;
        br = b; req = rq; rdy = rd; clr = cl;
        exp_q.push_back(exp_ctrl);
        #2;
        act_q.push_back(ctrl);
        @(posedge clk);
        #1;
        if (cl) begin
            exp_stall16 = 0;
            exp_stall4 = 0;
        end else if (!exp_ctrl[6]) begin
            if (exp_stall16 < 65535) exp_stall16++;
            if (exp_stall4 < 15) exp_stall4++;
        end
    endtask

    task automatic idle(input logic [6:0] exp_ctrl);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_ctrl);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (ctrl !== C_BOOT) begin
                failed++; $display("FAIL reset_ctrl[%0d]: got %b want %b", i, ctrl, C_BOOT);
            end
            tests_run++;
            if (stall_cnt !== 16'd0) begin
                failed++; $display("FAIL reset_stall[%0d]: got %0d want 0", i, stall_cnt);
            end
            tests_run++;
            if (err !== 1'b0) begin
                failed++; $display("FAIL reset_err[%0d]: got %b want 0", i, err);
            end
        end
        rst_n = 1'b1;
        exp_stall16 = 0;
        exp_stall4 = 0;
        #1;
        tests_run++;
        if (ctrl !== C_BOOT) begin
            failed++; $display("FAIL boot_cycle: got %b want %b", ctrl, C_BOOT);
        end
        @(posedge clk);
        #1;
        idle(C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL run_after_boot: got %b want %b", a, e);
            end
        end
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            failed++; $display("FAIL boot_no_count: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_load_use;
        int idx = 0;
        apply(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        tests_run++;
        if (stall_cnt !== 16'(exp_stall16) || exp_stall16 != 1) begin
            failed++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
        end
        idle(C_NORMAL);
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NORMAL);
        apply(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        apply(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NORMAL);
        apply(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL load_use[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
        tests_run++;
        if (stall_cnt !== 16'(exp_stall16)) begin
            failed++; $display("FAIL lu_stall_total: got %0d want %0d", stall_cnt, exp_stall16);
        end
    endtask

    task automatic test_branch;
        int idx = 0;
        apply(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_LU);
        apply(1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_BRANCH);
        idle(C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL branch[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
    endtask

    task automatic test_mem_wait;
        int idx = 0;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORMAL);
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            failed++; $display("FAIL mw_clear: got %0d want 0", stall_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2)
                apply(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_FREEZE);
            else
                apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_FREEZE);
        end
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NORMAL);
        idle(C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL mem_wait[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
        tests_run++;
        if (stall_cnt !== 16'd5) begin
            failed++; $display("FAIL mw_stall_cnt: got %0d want 5", stall_cnt);
        end
        tests_run++;
        if (err !== 1'b0) begin
            failed++; $display("FAIL mw_err: got %b want 0", err);
        end
    endtask

    task automatic test_timeout;
        int idx = 0;
        idle(C_NORMAL);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_FREEZE);
            tests_run++;
            if (err !== (i >= 15)) begin
                failed++; $display("FAIL timeout_err[%0d]: got %b want %b", i, err, (i >= 15));
            end
        end
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FREEZE);
        tests_run++;
        if (stall_cnt !== 16'd0) begin
            failed++; $display("FAIL clr_vs_stall: got %0d want 0", stall_cnt);
        end
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NORMAL);
        idle(C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL timeout_ctrl[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
        tests_run++;
        if (err !== 1'b1) begin
            failed++; $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_saturation;
        int idx = 0;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORMAL);
        for (int i = 0; i < 20; i++)
            apply(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_LU);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL sat_ctrl[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
        tests_run++;
        if (s_stall_cnt !== 4'd15 || exp_stall4 != 15) begin
            failed++; $display("FAIL sat_cnt4: got %0d want 15", s_stall_cnt);
        end
        tests_run++;
        if (stall_cnt !== 16'd20 || exp_stall16 != 20) begin
            failed++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt);
        end
    endtask

    task automatic test_mid_reset;
        int idx = 0;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_FREEZE);
        req = 1'b1; rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ctrl !== C_BOOT) begin
            failed++; $display("FAIL midrst_ctrl: got %b want %b", ctrl, C_BOOT);
        end
        tests_run++;
        if (stall_cnt !== 16'd0 || err !== 1'b0) begin
            failed++; $display("FAIL midrst_regs: got cnt=%0d err=%b want cnt=0 err=0", stall_cnt, err);
        end
        rst_n = 1'b1;
        exp_stall16 = 0;
        exp_stall4 = 0;
        @(posedge clk);
        #1;
        idle(C_NORMAL);
        while (exp_q.size() > 0) begin
            logic [6:0] e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            tests_run++;
            if (a !== e) begin
                failed++; $display("FAIL midrst_seq[%0d]: got %b want %b", idx, a, e);
            end
            idx++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
